// File: rtl/sldu_addrgen_operand_arbiter.sv
// Steers beats of the shared operand queue to exactly one of SLDU / ADDRGEN per routing command.
// Optional performance counters: define ARA_SLDU_ADDRGEN_ARB_PERF_EN.
module sldu_addrgen_operand_arbiter #(
  parameter int unsigned CmdDepth  = 2,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_target_i,
  input  logic [CntWidth-1:0]  cmd_len_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] operand_i,
  input  logic                 operand_valid_i,
  output logic                 operand_ready_o,
  output logic [DataWidth-1:0] sldu_operand_o,
  output logic                 sldu_operand_valid_o,
  input  logic                 sldu_operand_ready_i,
  output logic [DataWidth-1:0] addrgen_operand_o,
  output logic                 addrgen_operand_valid_o,
  input  logic                 addrgen_operand_ready_i,
  output logic                 busy_o
`ifdef ARA_SLDU_ADDRGEN_ARB_PERF_EN
  ,
  output logic [31:0]          perf_sldu_beats_o,
  output logic [31:0]          perf_addrgen_beats_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned PtrWidth = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int unsigned LvlWidth = $clog2(CmdDepth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(CmdDepth - 1);

  typedef struct packed {
    logic                target;
    logic [CntWidth-1:0] len;
  } cmd_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  cmd_t                mem [CmdDepth];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [LvlWidth-1:0] level;
  logic                full, empty, push, pop;
  cmd_t                head;

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                target_q, target_d;
  logic                active, sel_ready, xfer;

  assign full        = (level == LvlWidth'(CmdDepth));
  assign empty       = (level == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{target: cmd_target_i, len: cmd_len_i};
        wr_ptr      <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   level <= level + LvlWidth'(1);
        2'b01:   level <= level - LvlWidth'(1);
        default: level <= level;
      endcase
    end
  end

  assign active    = (state_q == ACTIVE);
  assign sel_ready = target_q ? addrgen_operand_ready_i : sldu_operand_ready_i;
  assign xfer      = active && operand_valid_i && sel_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // The last beat of a command pops the next head in the same cycle, so
  // consecutive commands stream without a bubble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          target_d = head.target;
          cnt_d    = head.len;
          if (head.len != '0) state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (cnt_q == CntWidth'(1)) begin
            if (!empty) begin
              pop      = 1'b1;
              target_d = head.target;
              cnt_d    = head.len;
              state_d  = (head.len == '0) ? IDLE : ACTIVE;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sldu_operand_o          = operand_i;
  assign addrgen_operand_o       = operand_i;
  assign sldu_operand_valid_o    = active && !target_q && operand_valid_i;
  assign addrgen_operand_valid_o = active && target_q && operand_valid_i;
  assign operand_ready_o         = active && sel_ready;
  assign busy_o                  = active || !empty;

`ifdef ARA_SLDU_ADDRGEN_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_sldu_beats_o    <= '0;
      perf_addrgen_beats_o <= '0;
      perf_stall_o         <= '0;
    end else begin
      if (xfer && !target_q) perf_sldu_beats_o <= perf_sldu_beats_o + 32'd1;
      if (xfer && target_q) perf_addrgen_beats_o <= perf_addrgen_beats_o + 32'd1;
      if (active && operand_valid_i && !sel_ready) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sldu_addrgen_operand_arbiter.md
Name: sldu_addrgen_operand_arbiter

Overview:
- Sequences the shared slide/address-generation operand queue output between the slide unit (SLDU) and the address generator (ADDRGEN).
- Accepts per-instruction routing commands {target, beat count} in order and steers each operand beat to exactly one consumer.
- The queue therefore never sees an OR of both consumer readies.
- Sits in each lane between the shared operand queue and the SLDU/ADDRGEN operand inputs.

Parameters:
- CmdDepth, 2, depth of the routing-command FIFO (≥1).
- CntWidth, 16, width of the beat-count field (max beats per command = 2^CntWidth-1).
- DataWidth, 64, operand beat width (ELEN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset; one clock, the reset port, synchronous, active-high
- cmd_target_i  in  1  0 = SLDU, 1 = ADDRGEN
- cmd_len_i  in  CntWidth  number of beats for this command
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- operand_i  in  DataWidth  beat from the shared operand queue
- operand_valid_i  in  1  queue beat valid
- operand_ready_o  out  1  beat consumed
- sldu_operand_o  out  DataWidth  beat to SLDU
- sldu_operand_valid_o  out  1  valid to SLDU
- sldu_operand_ready_i  in  1  SLDU ready
- addrgen_operand_o  out  DataWidth  beat to ADDRGEN
- addrgen_operand_valid_o  out  1  valid to ADDRGEN
- addrgen_operand_ready_i  in  1  ADDRGEN ready
- busy_o  out  1  command in flight or FIFO non-empty

Behaviour:
- Reset values:
  - FIFO empty; state IDLE; cnt_q=0; target_q=0.
  - All valid outputs 0; operand_ready_o=0; cmd_ready_o=1; busy_o=0.
  - Data outputs are don't-care but are driven as operand_i passthrough.
- Reset asserted mid-operation drops all pending commands and the active count in the same edge. Beats in the queue are not touched.
- Command FIFO:
  - Registered; push when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full only; there is no combinational dependence on pop.
  - A push while full is impossible by construction.
  - Push and pop in the same cycle are both allowed when not full.
  - A pushed entry is visible at the head on the next cycle.
- State machine:
  - IDLE: if FIFO non-empty, pop head, load target_q and cnt_q=len.
    - If len==0: discard the entry and stay IDLE (one cycle per zero-length command).
    - Else: go to ACTIVE.
  - ACTIVE: route beats. Transfer = operand_valid_i && selected ready.
    - On transfer: cnt_q decrements.
    - On transfer with cnt_q==1 and FIFO non-empty: pop next head in the same cycle, reload target_q/cnt_q, stay ACTIVE (back-to-back, no bubble).
    - If the popped next head has len==0: go to IDLE instead.
    - On transfer with cnt_q==1 and FIFO empty: go to IDLE.
- Routing:
  - Only in ACTIVE, and combinational (zero-latency pass-through).
  - target_q=0: sldu_operand_valid_o = operand_valid_i; operand_ready_o = sldu_operand_ready_i.
  - target_q=1: the same with addrgen_* ports.
  - The non-selected valid is always 0.
  - In IDLE: both valids are 0 and operand_ready_o=0, so the queue holds its beats.
  - Both data outputs carry operand_i unconditionally.
- Latency: a command accepted in cycle t can deliver its first beat at t+2 at the earliest.
- busy_o = (state==ACTIVE) || !empty.
- A ready from the non-selected consumer is ignored and has no effect.
- The counter never underflows. A beat arriving when no command is active waits indefinitely; this is not an error.

Optional Feature:
- Macro: ARA_SLDU_ADDRGEN_ARB_PERF_EN.
- When defined, add outputs perf_sldu_beats_o [31:0], perf_addrgen_beats_o [31:0] and perf_stall_o [31:0].
  - The beat counters increment on each transfer to that target.
  - perf_stall_o increments each ACTIVE cycle with operand_valid_i=1 and selected ready=0.
  - All counters wrap at 2^32, reset to 0 on rst_i, and saturate never.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then push {SLDU,len=3}; queue supplies 3 beats 0xA,0xB,0xC with SLDU always ready. Expect:
  - SLDU receives 0xA..0xC on cycles t+2..t+4.
  - addrgen_operand_valid_o stays 0.
  - busy_o drops after the third beat.
- Push {SLDU,2} then {ADDRGEN,2} back-to-back with both readies high. Expect:
  - Beats 1–2 go to SLDU, beats 3–4 go to ADDRGEN.
  - No bubble between beat 2 and beat 3.
- Fill FIFO with CmdDepth=2 commands plus one active. Expect cmd_ready_o=0 while full and =1 the cycle after a pop; a held cmd_valid_i is accepted exactly once.
- Push {ADDRGEN,0} then {SLDU,1}. Expect:
  - The zero-length command is consumed with no beat and no valid on ADDRGEN.
  - The single beat goes to SLDU.
- ACTIVE {ADDRGEN,4}, deassert addrgen_operand_ready_i for 5 cycles after 2 beats, while sldu_operand_ready_i=1. Expect:
  - operand_ready_o=0 during the stall and no SLDU valid.
  - The remaining 2 beats complete afterwards.
  - With the macro defined, perf_stall_o=5.
- Assert rst_i after 1 of 4 beats of {SLDU,4}. Expect all outputs at reset values next cycle, busy_o=0, cmd_ready_o=1, and no further SLDU valid until a new command.
